// File: rtl/ram_4k_reader.sv
// Sequential block reader for the 4K-word Hack RAM: streams `length` words from
// `base_addr` (12-bit wrap) and buffers the registered read latency in a small FIFO.
module ram_4k_reader #(
    parameter int READ_LATENCY = 1,
    parameter int DEPTH        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] base_addr,
    input  logic [12:0] length,
    output logic [11:0] mem_address,
    output logic        mem_load,
    output logic [15:0] mem_in,
    input  logic [15:0] mem_out,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + READ_LATENCY + 2) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                  state_q;
    logic [11:0]             base_q;
    logic [11:0]             addr_q;
    logic [12:0]             len_q;
    logic [12:0]             issued_q;
    logic                    addr_vld_q;
    logic [READ_LATENCY-1:0] flight_q;
    logic                    busy_q;
    logic                    done_q;

    logic [15:0]             fifo_q [DEPTH];
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [CW-1:0]           count_q;

    logic                    push;
    logic                    pop;
    logic                    room;
    logic [CW-1:0]           inflight;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reads on the bus or in the RAM pipeline; each one already owns a FIFO slot.
    always_comb begin
        inflight = CW'(addr_vld_q);
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(flight_q[i]);
        end
    end

    assign push      = flight_q[READ_LATENCY-1];
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign room      = (count_q + inflight - CW'(pop)) < CW'(DEPTH);
    assign out_data  = out_valid ? fifo_q[rd_ptr_q] : 16'h0000;

    assign mem_address = addr_q;
    assign mem_load    = 1'b0;
    assign mem_in      = 16'h0000;
    assign busy        = busy_q;
    assign done        = done_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flight_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            flight_q[0] <= addr_vld_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                flight_q[i] <= flight_q[i-1];
            end
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // The start edge itself issues the first read so data is ready two edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            addr_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            addr_vld_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (length == 13'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            base_q     <= base_addr;
                            len_q      <= length;
                            addr_q     <= base_addr;
                            addr_vld_q <= 1'b1;
                            issued_q   <= 13'd1;
                            busy_q     <= 1'b1;
                            state_q    <= (length == 13'd1) ? DRAIN : ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (room) begin
                        addr_q     <= base_q + issued_q[11:0];
                        addr_vld_q <= 1'b1;
                        issued_q   <= issued_q + 13'd1;
                        if (issued_q + 13'd1 == len_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Finish on the edge that pops the final word.
                    if (inflight == '0 && count_q == CW'(pop)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_4k_reader.sv
// Scoreboard bench for ram_4k_reader with a registered-read RAM4K model.
module tb_ram_4k_reader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] length;
    logic [11:0] mem_address;
    logic        mem_load;
    logic [15:0] mem_in;
    logic [15:0] mem_out;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    ram_4k_reader #(.READ_LATENCY(1), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .mem_address(mem_address),
        .mem_load   (mem_load),
        .mem_in     (mem_in),
        .mem_out    (mem_out),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [4096];
    always @(posedge clk) begin
        if (mem_load) ram[mem_address] <= mem_in;
        mem_out <= ram[mem_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];
    logic [11:0] addr_list [$];
    int          pops_done = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          first_valid_cyc = -1;
    int          valid_cnt = 0;
    bit          occ_en = 0;
    bit          rdy_mode = 0;
    int          n_edge = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: condition not met", name);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 out_ready = rdy_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Monitor: pops expected words and watches stalls, done and occupancy.
    initial begin
        logic [11:0] prev_addr;
        logic [15:0] stall_data;
        bit          stall_prev;
        bit          prev_done;
        logic [15:0] e;
        prev_addr  = 12'h000;
        stall_data = 16'h0000;
        stall_prev = 0;
        prev_done  = 0;
        forever begin
            @(negedge clk);
            check("mem_load", {31'b0, mem_load}, 32'd0);
            if (!rst_n) begin
                stall_prev = 0;
                prev_done  = 0;
                prev_addr  = mem_address;
                continue;
            end
            if (mem_address != prev_addr) addr_list.push_back(mem_address);
            prev_addr = mem_address;
            if (occ_en)
                check("occupancy", {31'b0, (addr_list.size() - pops_done) <= DEPTH}, 32'd1);
            if (stall_prev) begin
                check("stall_valid", {31'b0, out_valid}, 32'd1);
                check("stall_data", {16'b0, out_data}, {16'b0, stall_data});
            end
            if (out_valid) begin
                valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    flag_fail("unexpected_word");
                end else begin
                    e = exp_q.pop_front();
                    check("data", {16'b0, out_data}, {16'b0, e});
                end
                pops_done++;
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            if (done) begin
                if (prev_done) flag_fail("done_width");
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", {31'b0, busy}, 32'd0);
            end
            prev_done = done;
        end
    end

    task automatic kick(input logic [11:0] b, input logic [12:0] l);
        logic [11:0] a;
        for (int k = 0; k < int'(l); k++) begin
            a = b + 12'(k);
            exp_q.push_back({4'h0, a} ^ 16'hA5A5);
        end
        addr_list.delete();
        pops_done       = 0;
        first_valid_cyc = -1;
        done_cyc        = -1;
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        length    = l;
        @(posedge clk);
        #1;
        start  = 1'b0;
        n_edge = cyc;
    endtask

    task automatic wait_done(input int budget);
        int b;
        int t;
        b = done_cnt;
        t = 0;
        while (done_cnt == b && t < budget) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt == b) flag_fail("done_timeout");
    endtask

    initial begin
        int d0;
        int v0;
        int t;
        logic [11:0] wrap_exp [4];
        wrap_exp[0] = 12'hFFE;
        wrap_exp[1] = 12'hFFF;
        wrap_exp[2] = 12'h000;
        wrap_exp[3] = 12'h001;
        for (int i = 0; i < 4096; i++) ram[i] = 16'(i) ^ 16'hA5A5;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = 12'h000;
        length    = 13'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_address", {20'b0, mem_address}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {16'b0, out_data}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic stream
        d0 = done_cnt;
        kick(12'h010, 13'd8);
        check("basic_busy", {31'b0, busy}, 32'd1);
        wait_done(50);
        check("basic_first_valid", first_valid_cyc - n_edge, 32'd2);
        check("basic_done_time", done_cyc - n_edge, 32'd10);
        check("basic_left", exp_q.size(), 32'd0);
        repeat (4) @(posedge clk);
        check("basic_done_count", done_cnt - d0, 32'd1);

        // Wrap-around
        kick(12'hFFE, 13'd4);
        wait_done(50);
        check("wrap_issue_count", addr_list.size(), 32'd4);
        for (int i = 0; i < 4 && i < addr_list.size(); i++)
            check("wrap_addr", {20'b0, addr_list[i]}, {20'b0, wrap_exp[i]});
        check("wrap_left", exp_q.size(), 32'd0);

        // Backpressure
        rdy_mode = 1;
        occ_en   = 1;
        kick(12'h400, 13'd16);
        wait_done(600);
        occ_en   = 0;
        rdy_mode = 0;
        check("bp_left", exp_q.size(), 32'd0);
        check("bp_pops", pops_done, 32'd16);
        repeat (2) @(posedge clk);

        // Zero length
        v0 = valid_cnt;
        d0 = done_cnt;
        kick(12'h050, 13'd0);
        check("zero_busy", {31'b0, busy}, 32'd0);
        wait_done(10);
        check("zero_done_time", done_cyc - n_edge, 32'd0);
        repeat (4) @(posedge clk);
        check("zero_no_valid", valid_cnt - v0, 32'd0);
        check("zero_done_count", done_cnt - d0, 32'd1);

        // Full length
        kick(12'h123, 13'd4096);
        wait_done(5000);
        check("full_done_time", done_cyc - n_edge, 32'd4098);
        check("full_last_addr", {20'b0, mem_address}, 32'h122);
        check("full_left", exp_q.size(), 32'd0);

        // Start while busy
        d0 = done_cnt;
        kick(12'h200, 13'd10);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start     = 1'b1;
        base_addr = 12'h300;
        length    = 13'd5;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(100);
        check("busy_start_done_time", done_cyc - n_edge, 32'd12);
        repeat (10) @(posedge clk);
        check("busy_start_left", exp_q.size(), 32'd0);
        check("busy_start_done_count", done_cnt - d0, 32'd1);
        check("busy_start_idle", {31'b0, busy}, 32'd0);

        // Reset mid-transfer
        kick(12'h700, 13'd20);
        t = 0;
        while (pops_done < 5 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (pops_done < 5) flag_fail("reset_wait_timeout");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_mem_address", {20'b0, mem_address}, 32'd0);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_out_data", {16'b0, out_data}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        check("mid_rst_no_done", done_cnt - d0, 32'd0);
        kick(12'h800, 13'd6);
        wait_done(50);
        check("post_rst_done_time", done_cyc - n_edge, 32'd8);
        check("post_rst_left", exp_q.size(), 32'd0);
        check("post_rst_pops", pops_done, 32'd6);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_4k_reader.md
# ram_4k_reader

Sequential read initiator for the 4K-word Hack RAM (`bram_ram_4k`). On a `start` pulse it streams `length` consecutive words from a base address, wrapping modulo 4096. It absorbs the RAM's registered read latency in a small FIFO and delivers words over a valid/ready stream. It sits between the RAM4K and any consumer that needs a block read, such as a screen scanner, UART dumper or checksum unit.

## Interface
- READ_LATENCY, 1, cycles from `mem_address` driven to matching `mem_out` valid (BRAM registered read); legal 1..3
- DEPTH, 4, output FIFO depth in words; must be >= READ_LATENCY+1
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  begin a transfer; sampled only in IDLE
- base_addr  input  12  first word address; sampled with `start`
- length  input  13  word count 0..4096; sampled with `start`
- mem_address  output  12  to RAM4K `address`
- mem_load  output  1  to RAM4K `load`; constant 0
- mem_in  output  16  to RAM4K `in`; constant 16'h0000
- mem_out  input  16  from RAM4K `out`
- out_data  output  16  streamed word (FIFO head)
- out_valid  output  1  `out_data` is valid
- out_ready  input  1  consumer accepts on `out_valid && out_ready`
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse when the last word is accepted, or for a zero-length start

## Operation
- Reset values: `mem_address`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0. The FIFO is empty, all counters are 0 and the state is IDLE.
- IDLE
  - `start`=1 with `length`!=0: latch `base_addr` and `length`, go to ISSUE, `busy`=1.
  - `start`=1 with `length`=0: go to DONE and issue no reads.
- ISSUE
  - Each cycle, issue a read when `occupancy + inflight - pop < DEPTH`, where `pop` = `out_valid && out_ready`.
  - An issue drives `mem_address` = `base + issued` (mod 4096, 12-bit wrap) and increments `issued`.
  - When `issued` == `length`, go to DRAIN.
- DRAIN: no further issues. Go to DONE when `inflight`==0, the FIFO is empty, and the last word has been popped.
- DONE: `done`=1 for exactly one cycle, `busy`=0, next state is IDLE.
- In-flight tracking: a READ_LATENCY-deep valid shift register. The bit at the tail writes `mem_out` into the FIFO.
- The FIFO never overflows. The issue rule guarantees a slot for every in-flight read.
- `mem_address` holds its last value when not issuing.
- `start` is ignored while `busy`=1. `base_addr` and `length` may change freely after they are sampled.
- `rst_n` low at any time, including mid-transfer, returns to reset values immediately. In-flight data is discarded, and no `done` is produced for the aborted transfer.

## Timing
- Reads issue on cycles N+1, N+2, … after the edge N that samples `start`.
- The word for an address issued in cycle t appears on `mem_out` in cycle t+READ_LATENCY and is written into the FIFO at the end of that cycle.
- With READ_LATENCY=1, `out_valid` first rises 2 cycles after the sampling edge.
- With `out_ready` held high, throughput is one word per clock. A `length`=L transfer asserts `done` L+2 cycles after the sampling edge.
- Backpressure: `out_data` and `out_valid` stay stable while `out_valid && !out_ready`.
- FIFO push and pop in the same cycle leave the occupancy unchanged.
- `done` and `busy` falling happen on the same edge.
- A new `start` is accepted on the first cycle after the `done` cycle.

## Test plan
- Basic stream: RAM preloaded with `mem[i]=i^16'hA5A5`; base=0x010, length=8, `out_ready`=1 → 8 words 0x10^A5A5 … 0x17^A5A5 in order on 8 consecutive cycles; `done` pulses once; `mem_load` stays 0 throughout.
- Wrap-around: base=0xFFE, length=4 → addresses issued 0xFFE, 0xFFF, 0x000, 0x001; data matches.
- Backpressure: length=16, `out_ready` random at 30% duty → all 16 words in order, none dropped or duplicated; `out_data` stable during stalls; FIFO occupancy never exceeds DEPTH.
- Zero and full length:
  - length=0 → `done` the cycle after start, `out_valid` never asserted.
  - length=4096 → 4096 words, last address issued is base-1 mod 4096.
- Start while busy: pulse `start` with new base mid-transfer → ignored; the original sequence completes unchanged.
- Reset mid-op: assert `rst_n`=0 after 5 of 20 words → all outputs return to reset values asynchronously; no `done`; a fresh start after release streams correctly from its base.
